// File: rtl/bcd_display_scanner.sv
// Multiplexed common-anode 7-segment scanner for a chain of BCD digits.
// Digit values are snapshotted once per frame so a frame never mixes old and new values.
module bcd_display_scanner #(
   parameter int DIGITS        = 4,
   parameter int REFRESH_DIV   = 100000,
   parameter int BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   digits_in,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  blank,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   logic [DW-1:0]             div_q, div_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [DIGITS-1:0][3:0]    dig_q, dig_d;
   logic [DIGITS-1:0]         sdp_q, sdp_d;
   logic [DIGITS-1:0]         an_q, an_d;
   logic [6:0]                seg_q, seg_d;
   logic                      dp_q, dp_d;
   logic                      fd_q, fd_d;

   logic                      tick, wrap, run, blanked;
   logic [DIGITS-1:0]         lz;
   logic [3:0]                cur;
   logic [6:0]                dec;

   assign tick = (div_q == DIV_LAST);
   assign wrap = tick && (idx_q == IDX_LAST);

   always_comb begin
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = idx_q;
      if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      dig_d = wrap ? digits_in : dig_q;
      sdp_d = wrap ? dp_in : sdp_q;
      fd_d  = wrap;
   end

   // lz[i]: every shadow digit from i up to the MSD is zero with no decimal point
   always_comb begin
      lz  = '0;
      run = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         run   = run & (dig_q[i] == 4'd0) & ~sdp_q[i];
         lz[i] = run;
      end
   end

   assign blanked = (BLANK_LEADING != 0) && (idx_q != '0) && lz[idx_q];
   assign cur     = dig_q[idx_q];

   always_comb begin
      case (cur)
         4'd0:    dec = 7'h40;
         4'd1:    dec = 7'h79;
         4'd2:    dec = 7'h24;
         4'd3:    dec = 7'h30;
         4'd4:    dec = 7'h19;
         4'd5:    dec = 7'h12;
         4'd6:    dec = 7'h02;
         4'd7:    dec = 7'h78;
         4'd8:    dec = 7'h00;
         4'd9:    dec = 7'h10;
         default: dec = 7'h3F;
      endcase
   end

   always_comb begin
      an_d  = '1;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!blank && !blanked) begin
         an_d  = ~(DIGITS'(1) << idx_q);
         seg_d = dec;
         dp_d  = ~sdp_q[idx_q];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= '0;
         idx_q <= '0;
         dig_q <= '0;
         sdp_q <= '0;
         an_q  <= '1;
         seg_q <= 7'h7F;
         dp_q  <= 1'b1;
         fd_q  <= 1'b0;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         dig_q <= dig_d;
         sdp_q <= sdp_d;
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= dp_d;
         fd_q  <= fd_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench: a per-edge arithmetic model pushes expected outputs, a negedge monitor pops and compares.
module tb_bcd_display_scanner;

   localparam int D  = 4;
   localparam int R  = 4;
   localparam int FR = D * R;

   logic          clk, rst_n, blank;
   logic [15:0]   digits_in;
   logic [3:0]    dp_in;
   logic [6:0]    seg_a, seg_b;
   logic          dp_a, dp_b, fd_a, fd_b;
   logic [3:0]    an_a, an_b;

   bcd_display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_LEADING(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
      .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

   bcd_display_scanner #(.DIGITS(D), .REFRESH_DIV(R), .BLANK_LEADING(0)) u_dut_nb (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in), .blank(blank),
      .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

   typedef struct packed {
      logic [3:0] an_a; logic [6:0] seg_a; logic dp_a;
      logic [3:0] an_b; logic [6:0] seg_b; logic dp_b;
      logic       fd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected appearance of slot idx given a frame's digit/dp snapshot.
   function automatic void slot(input int idx, input logic [15:0] dg, input logic [3:0] dpv,
                                input logic blk, input bit bl,
                                output logic [3:0] a, output logic [6:0] s, output logic d);
      logic [15:0] hi;
      logic [3:0]  hdp;
      hi  = dg >> (4 * idx);
      hdp = dpv >> idx;
      if (blk || (bl && idx > 0 && hi == 16'd0 && hdp == 4'd0)) begin
         a = 4'hF; s = 7'h7F; d = 1'b1;
      end else begin
         a = ~(4'b0001 << idx);
         s = SEG_TAB[int'(dg[4*idx +: 4])];
         d = ~dpv[idx];
      end
   endfunction

   // Model: n = edges since reset release; slot and frame follow from n by plain arithmetic.
   int          n;
   logic [15:0] m_dig;
   logic [3:0]  m_dp;
   always @(posedge clk or negedge rst_n) begin
      exp_t e;
      if (!rst_n) begin
         n = 0; m_dig = '0; m_dp = '0;
         sb.delete();
      end else begin
         slot((n / R) % D, m_dig, m_dp, blank, 1'b1, e.an_a, e.seg_a, e.dp_a);
         slot((n / R) % D, m_dig, m_dp, blank, 1'b0, e.an_b, e.seg_b, e.dp_b);
         e.fd = ((n + 1) % FR == 0);
         sb.push_back(e);
         if (e.fd) begin
            m_dig = digits_in;
            m_dp  = dp_in;
         end
         n++;
      end
   end

   int cyc, last_fd;
   bit have_fd;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         cyc = 0; have_fd = 0;
         chk("rst_an", 32'(an_a), 32'hF);
         chk("rst_seg", 32'(seg_a), 32'h7F);
         chk("rst_dp", 32'(dp_a), 32'h1);
         chk("rst_fd", 32'(fd_a), 32'h0);
         chk("rst_an_nb", 32'(an_b), 32'hF);
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         cyc++;
         chk("an", 32'(an_a), 32'(e.an_a));
         chk("seg", 32'(seg_a), 32'(e.seg_a));
         chk("dp", 32'(dp_a), 32'(e.dp_a));
         chk("frame_done", 32'(fd_a), 32'(e.fd));
         chk("an_nb", 32'(an_b), 32'(e.an_b));
         chk("seg_nb", 32'(seg_b), 32'(e.seg_b));
         chk("dp_nb", 32'(dp_b), 32'(e.dp_b));
         chk("frame_done_nb", 32'(fd_b), 32'(e.fd));
         if (fd_a) begin
            if (have_fd) chk("fd_period", 32'(cyc - last_fd), 32'(FR));
            have_fd = 1;
            last_fd = cyc;
         end
      end
   end

   task automatic step(input int k);
      repeat (k) @(negedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] r;
      rst_n = 1'b0; blank = 1'b0; digits_in = '0; dp_in = '0;
      step(3);
      rst_n = 1'b1;
      step(12);
      digits_in = 16'h1234; dp_in = 4'b0000;
      step(40);
      digits_in = 16'h0042; dp_in = 4'b0100;
      step(40);
      digits_in = 16'h1111;
      step(38);
      digits_in = 16'h9999;
      step(40);
      digits_in = 16'h00A0; dp_in = 4'b0000;
      step(40);
      blank = 1'b1;
      step(40);
      blank = 1'b0;
      step(20);
      digits_in = 16'h5678; dp_in = 4'b1001;
      step(7);
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(40);
      for (int it = 0; it < 250; it++) begin
         r = 16'($urandom);
         case ($urandom_range(0, 3))
            0: r = r & 16'h000F;
            1: r = r & 16'h00FF;
            2: r = r & 16'h0FFF;
            default: ;
         endcase
         digits_in = r;
         dp_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
         blank = ($urandom_range(0, 9) == 0);
         step($urandom_range(1, 12));
      end
      blank = 1'b0;
      step(3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
